// File: rtl/axi_rd_arbiter.sv
// Two-requester round-robin arbiter in front of a single AXI read master.
// Latches the winner's burst command, forwards beats to the owner and flags beat-count mismatches.
module axi_rd_arbiter #(
    parameter int ADDR_WIDTH = 30,
    parameter int DATA_WIDTH = 64,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_req0,
    input  logic                  rd_req1,
    input  logic [ADDR_WIDTH-1:0] rd_addr0,
    input  logic [ADDR_WIDTH-1:0] rd_addr1,
    input  logic [LEN_WIDTH-1:0]  rd_len0,
    input  logic [LEN_WIDTH-1:0]  rd_len1,
    output logic                  rd_grant0,
    output logic                  rd_grant1,
    output logic                  rd_vld0,
    output logic                  rd_vld1,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_done0,
    output logic                  rd_done1,
    output logic                  len_err,
    output logic                  m_rd_start,
    output logic [ADDR_WIDTH-1:0] m_rd_addr,
    output logic [LEN_WIDTH-1:0]  m_rd_len,
    input  logic                  m_rd_ready,
    input  logic                  m_rd_done,
    input  logic                  m_axi_r_handshake,
    input  logic [DATA_WIDTH-1:0] m_rd_data
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        START = 3'd2,
        WAIT  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_grant;
    logic [LEN_WIDTH:0] beat_cnt;
    logic [LEN_WIDTH:0] beat_exp;
    logic               win0;
    logic               win1;
    logic               beat;

    // Requester 1 wins when alone, or when both ask and requester 0 was served last.
    assign win1 = rd_req1 & (~rd_req0 | ~last_grant);
    assign win0 = rd_req0 & ~win1;

    assign beat     = (state == WAIT) & m_axi_r_handshake;
    assign beat_exp = {1'b0, m_rd_len} + {{LEN_WIDTH{1'b0}}, 1'b1};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rd_req0 | rd_req1) state_nxt = ARB;
            ARB:     state_nxt = (win0 | win1) ? START : IDLE;
            START:   if (m_rd_ready) state_nxt = WAIT;
            WAIT:    if (m_rd_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            beat_cnt   <= '0;
            len_err    <= 1'b0;
            rd_grant0  <= 1'b0;
            rd_grant1  <= 1'b0;
            m_rd_addr  <= '0;
            m_rd_len   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                ARB: begin
                    if (win0 | win1) begin
                        rd_grant0  <= win0;
                        rd_grant1  <= win1;
                        last_grant <= win1;
                        m_rd_addr  <= win1 ? rd_addr1 : rd_addr0;
                        m_rd_len   <= win1 ? rd_len1 : rd_len0;
                    end
                end
                WAIT: begin
                    if (m_axi_r_handshake)
                        beat_cnt <= beat_cnt + {{LEN_WIDTH{1'b0}}, 1'b1};
                end
                DONE: begin
                    if (beat_cnt != beat_exp)
                        len_err <= 1'b1;
                    rd_grant0 <= 1'b0;
                    rd_grant1 <= 1'b0;
                    beat_cnt  <= '0;
                end
                default: ;
            endcase
        end
    end

    // Strobes are decoded from state so a reset instantly silences them.
    assign m_rd_start = (state == START) & m_rd_ready;
    assign rd_vld0    = beat & rd_grant0;
    assign rd_vld1    = beat & rd_grant1;
    assign rd_data_o  = (rd_vld0 | rd_vld1) ? m_rd_data : '0;
    assign rd_done0   = (state == DONE) & rd_grant0;
    assign rd_done1   = (state == DONE) & rd_grant1;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: single bursts, round-robin, ready stall,
// short burst error, 256-beat burst and reset during a burst.
module tb_axi_rd_arbiter;

    localparam int AW = 30;
    localparam int DW = 64;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_req0, rd_req1;
    logic [AW-1:0] rd_addr0, rd_addr1;
    logic [LW-1:0] rd_len0, rd_len1;
    logic          rd_grant0, rd_grant1;
    logic          rd_vld0, rd_vld1;
    logic [DW-1:0] rd_data_o;
    logic          rd_done0, rd_done1;
    logic          len_err;
    logic          m_rd_start;
    logic [AW-1:0] m_rd_addr;
    logic [LW-1:0] m_rd_len;
    logic          m_rd_ready, m_rd_done, m_axi_r_handshake;
    logic [DW-1:0] m_rd_data;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .rd_req0(rd_req0), .rd_req1(rd_req1),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_len0(rd_len0), .rd_len1(rd_len1),
        .rd_grant0(rd_grant0), .rd_grant1(rd_grant1),
        .rd_vld0(rd_vld0), .rd_vld1(rd_vld1),
        .rd_data_o(rd_data_o),
        .rd_done0(rd_done0), .rd_done1(rd_done1),
        .len_err(len_err),
        .m_rd_start(m_rd_start), .m_rd_addr(m_rd_addr), .m_rd_len(m_rd_len),
        .m_rd_ready(m_rd_ready), .m_rd_done(m_rd_done),
        .m_axi_r_handshake(m_axi_r_handshake), .m_rd_data(m_rd_data)
    );

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chkw(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // From IDLE: one edge into ARB, one edge into START with the grant visible.
    task automatic arb_to_start(input logic g1, input logic [63:0] addr, input logic [63:0] len);
        cyc();
        chk1("arb_grant0_low", rd_grant0, 1'b0);
        chk1("arb_grant1_low", rd_grant1, 1'b0);
        cyc();
        chk1("grant0", rd_grant0, !g1);
        chk1("grant1", rd_grant1, g1);
        chkw("m_rd_addr", 64'(m_rd_addr), addr);
        chkw("m_rd_len", 64'(m_rd_len), len);
    endtask

    task automatic start_step();
        chk1("m_rd_start", m_rd_start, 1'b1);
        cyc();
        chk1("m_rd_start_once", m_rd_start, 1'b0);
    endtask

    // Delivers n beats in WAIT, the last one together with m_rd_done, then checks DONE.
    task automatic beats(input int n, input logic g1);
        int good = 0;
        logic [63:0] exp_data;
        for (int i = 0; i < n; i++) begin
            exp_data = 64'hBEEF_0000_0000_0000 | 64'(i);
            m_axi_r_handshake = 1'b1;
            m_rd_data = exp_data;
            m_rd_done = (i == n - 1);
            #1;
            if (rd_vld0 === !g1 && rd_vld1 === g1 && rd_data_o === exp_data)
                good++;
            cyc();
        end
        m_axi_r_handshake = 1'b0;
        m_rd_done = 1'b0;
        m_rd_data = '0;
        #1;
        chkw("beats_forwarded", 64'(good), 64'(n));
        chk1("rd_done0", rd_done0, !g1);
        chk1("rd_done1", rd_done1, g1);
        chk1("vld0_in_done", rd_vld0, 1'b0);
        chk1("vld1_in_done", rd_vld1, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        rd_req0 = 1'b0; rd_req1 = 1'b0;
        rd_addr0 = '0; rd_addr1 = '0;
        rd_len0 = '0; rd_len1 = '0;
        m_rd_ready = 1'b0; m_rd_done = 1'b0; m_axi_r_handshake = 1'b0;
        m_rd_data = 64'hFFFF_FFFF_FFFF_FFFF;
        cyc(); cyc();
        chk1("rst_grant0", rd_grant0, 1'b0);
        chk1("rst_grant1", rd_grant1, 1'b0);
        chk1("rst_start", m_rd_start, 1'b0);
        chkw("rst_addr", 64'(m_rd_addr), 64'd0);
        chkw("rst_len", 64'(m_rd_len), 64'd0);
        chkw("rst_data", rd_data_o, 64'd0);
        chk1("rst_len_err", len_err, 1'b0);
        m_rd_data = '0;
        rst = 1'b0;
        cyc();

        // Single one-beat burst from requester 0.
        rd_req0 = 1'b1; rd_addr0 = 30'd8; rd_len0 = 8'd0; m_rd_ready = 1'b1;
        arb_to_start(1'b0, 64'd8, 64'd0);
        rd_req0 = 1'b0;
        #1;
        start_step();
        beats(1, 1'b0);
        cyc();
        chk1("t1_len_err", len_err, 1'b0);
        chk1("t1_grant0_clr", rd_grant0, 1'b0);
        chk1("t1_done0_pulse", rd_done0, 1'b0);

        // Requester 1 asks for 4 beats, master delivers 2.
        rd_req1 = 1'b1; rd_addr1 = 30'h100; rd_len1 = 8'd3;
        arb_to_start(1'b1, 64'h100, 64'd3);
        rd_req1 = 1'b0; rd_addr1 = 30'h3FF; rd_len1 = 8'd9;
        #1;
        start_step();
        chkw("hold_addr", 64'(m_rd_addr), 64'h100);
        beats(2, 1'b1);
        cyc();
        chk1("short_len_err", len_err, 1'b1);

        // Both held: grants alternate 0,1,0,1.
        rd_req0 = 1'b1; rd_addr0 = 30'h10; rd_len0 = 8'd1;
        rd_req1 = 1'b1; rd_addr1 = 30'h20; rd_len1 = 8'd1;
        for (int b = 0; b < 4; b++) begin
            arb_to_start(logic'(b % 2), (b % 2 == 1) ? 64'h20 : 64'h10, 64'd1);
            start_step();
            beats(2, logic'(b % 2));
            cyc();
        end
        rd_req0 = 1'b0; rd_req1 = 1'b0;
        chk1("len_err_sticky", len_err, 1'b1);

        // Reset clears the sticky flag asynchronously.
        rst = 1'b1;
        #1;
        chk1("len_err_cleared", len_err, 1'b0);
        cyc();
        rst = 1'b0;
        cyc();

        // Master not ready for 5 cycles after the grant.
        rd_req0 = 1'b1; rd_addr0 = 30'h40; rd_len0 = 8'd0; m_rd_ready = 1'b0;
        arb_to_start(1'b0, 64'h40, 64'd0);
        rd_req0 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk1("stall_start", m_rd_start, 1'b0);
            cyc();
        end
        m_rd_ready = 1'b1;
        #1;
        start_step();
        beats(1, 1'b0);
        cyc();
        chk1("stall_len_err", len_err, 1'b0);

        // 256-beat burst, last beat coincident with m_rd_done.
        rd_req0 = 1'b1; rd_addr0 = 30'h3000; rd_len0 = 8'd255;
        arb_to_start(1'b0, 64'h3000, 64'd255);
        rd_req0 = 1'b0;
        #1;
        start_step();
        beats(256, 1'b0);
        cyc();
        chk1("long_len_err", len_err, 1'b0);

        // Reset in the middle of a requester-1 burst.
        rd_req1 = 1'b1; rd_addr1 = 30'h55; rd_len1 = 8'd3;
        arb_to_start(1'b1, 64'h55, 64'd3);
        rd_req1 = 1'b0;
        #1;
        start_step();
        m_axi_r_handshake = 1'b1; m_rd_data = 64'h1234;
        #1;
        chk1("pre_rst_vld1", rd_vld1, 1'b1);
        cyc();
        rst = 1'b1;
        #1;
        chk1("mrst_grant1", rd_grant1, 1'b0);
        chk1("mrst_vld1", rd_vld1, 1'b0);
        chkw("mrst_data", rd_data_o, 64'd0);
        chk1("mrst_start", m_rd_start, 1'b0);
        chkw("mrst_addr", 64'(m_rd_addr), 64'd0);
        chkw("mrst_len", 64'(m_rd_len), 64'd0);
        chk1("mrst_done1", rd_done1, 1'b0);
        cyc();
        chk1("mrst_done1_hold", rd_done1, 1'b0);
        rst = 1'b0;
        m_axi_r_handshake = 1'b0; m_rd_done = 1'b1;
        cyc();
        chk1("post_rst_done1", rd_done1, 1'b0);
        chk1("post_rst_start", m_rd_start, 1'b0);
        m_rd_done = 1'b0;
        rd_req0 = 1'b1; rd_addr0 = 30'h77; rd_len0 = 8'd0;
        rd_req1 = 1'b1; rd_addr1 = 30'h88; rd_len1 = 8'd0;
        arb_to_start(1'b0, 64'h77, 64'd0);
        rd_req0 = 1'b0; rd_req1 = 1'b0;
        #1;
        start_step();
        beats(1, 1'b0);
        cyc();
        chk1("final_len_err", len_err, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi_rd_arbiter.md
AXI_RD_ARBITER -- requirements
Module: axi_rd_arbiter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 30, the read address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 64, the read data width.
REQ-003 SHALL have parameter LEN_WIDTH, default 8, the burst length field width (beats = len+1).
REQ-004 SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have ports rd_req0/rd_req1, input, 1 each, level request from requester 0/1.
REQ-007 SHALL have ports rd_addr0/rd_addr1, input, ADDR_WIDTH, burst start address per requester.
REQ-008 SHALL have ports rd_len0/rd_len1, input, LEN_WIDTH, burst length per requester.
REQ-009 SHALL have ports rd_grant0/rd_grant1, output, 1 each, high while that requester owns the master.
REQ-010 SHALL have ports rd_vld0/rd_vld1, output, 1 each, data beat valid for requester 0/1.
REQ-011 SHALL have port rd_data_o, output, DATA_WIDTH, shared read data to requesters.
REQ-012 SHALL have ports rd_done0/rd_done1, output, 1 each, one-cycle burst complete pulse.
REQ-013 SHALL have port len_err, output, 1, sticky flag: beat count mismatch seen.
REQ-014 SHALL have ports m_rd_start (output, 1), m_rd_addr (output, ADDR_WIDTH) and m_rd_len (output, LEN_WIDTH), the command to the AXI read master.
REQ-015 SHALL have ports m_rd_ready, m_rd_done and m_axi_r_handshake (input, 1 each), and m_rd_data (input, DATA_WIDTH), the status and data from the AXI read master.

Function
REQ-016 SHALL implement FSM states IDLE, ARB, START, WAIT, DONE.
REQ-017 SHALL, in IDLE, go to ARB when rd_req0|rd_req1; otherwise stay in IDLE.
REQ-018 SHALL arbitrate round-robin in ARB: the requester not granted last wins if both request; the sole requester wins otherwise; the last_grant reset value makes requester 0 win first.
REQ-019 SHALL latch the winner's addr/len into m_rd_addr/m_rd_len in ARB, assert the winner's rd_grantN, update last_grant, and go to START.
REQ-020 SHALL, in START, pulse m_rd_start for exactly one cycle when m_rd_ready=1, then go to WAIT; while m_rd_ready=0, hold in START with m_rd_start=0.
REQ-021 SHALL, in WAIT, count m_axi_r_handshake beats; each beat drives rd_data_o=m_rd_data combinationally and asserts rd_vldN for the granted requester only, with zero added latency.
REQ-022 SHALL, on m_rd_done in WAIT, go to DONE; a handshake in the same cycle as m_rd_done is counted and forwarded.
REQ-023 SHALL, in DONE, pulse rd_doneN for one cycle, set len_err if beat count != latched len+1, clear rd_grantN and the counter, and return to IDLE.
REQ-024 SHALL hold m_rd_addr/m_rd_len and the grant stable from ARB through DONE; requester input changes or request drops mid-burst are ignored.
REQ-025 SHALL size the beat counter to LEN_WIDTH+1 bits so that a length of 255 (256 beats) does not wrap.
REQ-026 SHALL never assert both grants, both rd_vld, or both rd_done in one cycle.
REQ-027 SHALL ignore m_rd_done and m_axi_r_handshake outside WAIT.
REQ-028 SHALL give a request held continuously after its rd_done a new grant only after any pending request from the other requester (no starvation).

Reset
REQ-029 SHALL, while rst=1, force state=IDLE, last_grant=1, counter=0, len_err=0, and every output to 0, including m_rd_addr/m_rd_len and rd_data_o.
REQ-030 SHALL, when reset asserts mid-burst, issue no further m_rd_start and no rd_done, and forward no rd_vld, until a new arbitration after reset release.

Verification
REQ-031 SHALL cover: rd_req0=1, addr0=8, len0=0, m_rd_ready=1 -> grant0, one m_rd_start with m_rd_addr=8/m_rd_len=0, one rd_vld0, rd_done0 pulse, len_err=0.
REQ-032 SHALL cover: rd_req0 and rd_req1 both held high -> grants alternate 0,1,0,1 over four bursts.
REQ-033 SHALL cover: m_rd_ready=0 for 5 cycles after grant -> m_rd_start stays 0, then pulses exactly once when m_rd_ready=1.
REQ-034 SHALL cover: len1=3 but the master delivers 2 beats then m_rd_done -> rd_done1 pulses and len_err=1, sticky until rst.
REQ-035 SHALL cover: len0=255 with 256 handshakes, the last coincident with m_rd_done -> 256 rd_vld0 beats, len_err=0.
REQ-036 SHALL cover: rst=1 during WAIT -> all outputs 0 next edge; rd_done absent; the next burst after release grants requester 0.
